// File: rtl/rename_table_ckpt.sv
// rtl/rename_table_ckpt.sv - register rename table with circular checkpoint FIFO
module rename_table_ckpt #(
   parameter int NUM_REGS = 32,
   parameter int TAG_W    = 5,
   parameter int NUM_CKPT = 4,
   localparam int NUM_REGS_LOG2 = $clog2(NUM_REGS),
   localparam int CKPT_W        = $clog2(NUM_CKPT)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     flush_i,
   input  logic                     push0_i,
   input  logic                     push1_i,
   input  logic [NUM_REGS_LOG2-1:0] push_reg_addr0_i,
   input  logic [NUM_REGS_LOG2-1:0] push_reg_addr1_i,
   input  logic [TAG_W-1:0]         push_rob_addr0_i,
   input  logic [TAG_W-1:0]         push_rob_addr1_i,
   input  logic [NUM_REGS_LOG2-1:0] read_reg_addr0_pipe0_i,
   input  logic [NUM_REGS_LOG2-1:0] read_reg_addr1_pipe0_i,
   input  logic [NUM_REGS_LOG2-1:0] read_reg_addr0_pipe1_i,
   input  logic [NUM_REGS_LOG2-1:0] read_reg_addr1_pipe1_i,
   output logic [TAG_W-1:0]         read_rob_addr0_pipe0_o,
   output logic [TAG_W-1:0]         read_rob_addr1_pipe0_o,
   output logic [TAG_W-1:0]         read_rob_addr0_pipe1_o,
   output logic [TAG_W-1:0]         read_rob_addr1_pipe1_o,
   output logic                     read_vld0_pipe0_o,
   output logic                     read_vld1_pipe0_o,
   output logic                     read_vld0_pipe1_o,
   output logic                     read_vld1_pipe1_o,
   input  logic                     pop0_i,
   input  logic                     pop1_i,
   input  logic [NUM_REGS_LOG2-1:0] pop_reg_addr0_i,
   input  logic [NUM_REGS_LOG2-1:0] pop_reg_addr1_i,
   input  logic [TAG_W-1:0]         pop_rob_addr0_i,
   input  logic [TAG_W-1:0]         pop_rob_addr1_i,
   input  logic                     ckpt_save_i,
   output logic [CKPT_W-1:0]        ckpt_save_id_o,
   input  logic                     ckpt_release_i,
   input  logic                     ckpt_restore_i,
   input  logic [CKPT_W-1:0]        ckpt_restore_id_i,
   output logic                     ckpt_full_o,
   output logic                     ckpt_err_o
);

   typedef logic [NUM_REGS-1:0][TAG_W-1:0] map_t;
   typedef logic [NUM_REGS-1:0]            vld_t;

   localparam logic [CKPT_W:0] FULL_CNT = (CKPT_W+1)'(NUM_CKPT);

   map_t              map_q, map_d;
   vld_t              vld_q, vld_d;
   map_t              ckpt_map_q [NUM_CKPT];
   map_t              ckpt_map_d [NUM_CKPT];
   vld_t              ckpt_vld_q [NUM_CKPT];
   vld_t              ckpt_vld_d [NUM_CKPT];
   logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CKPT_W:0]   count_q, count_d;
   logic              err_q, err_d;
   logic [CKPT_W-1:0] rst_dist;
   logic              restore_live, rel_ok, save_ok;

   // Commit clears a mapping only while it still names the committing tag.
   function automatic vld_t apply_pops(input map_t m, input vld_t v);
      vld_t r;
      r = v;
      if (pop0_i && (pop_reg_addr0_i != '0) && (m[pop_reg_addr0_i] == pop_rob_addr0_i))
         r[pop_reg_addr0_i] = 1'b0;
      if (pop1_i && (pop_reg_addr1_i != '0) && (m[pop_reg_addr1_i] == pop_rob_addr1_i))
         r[pop_reg_addr1_i] = 1'b0;
      return r;
   endfunction

   function automatic logic [TAG_W-1:0] rd_tag(input map_t m, input logic [NUM_REGS_LOG2-1:0] a);
      return (a == '0) ? '0 : m[a];
   endfunction

   function automatic logic rd_vld(input vld_t v, input logic [NUM_REGS_LOG2-1:0] a);
      return (a == '0) ? 1'b0 : v[a];
   endfunction

   assign read_rob_addr0_pipe0_o = rd_tag(map_q, read_reg_addr0_pipe0_i);
   assign read_rob_addr1_pipe0_o = rd_tag(map_q, read_reg_addr1_pipe0_i);
   assign read_rob_addr0_pipe1_o = rd_tag(map_q, read_reg_addr0_pipe1_i);
   assign read_rob_addr1_pipe1_o = rd_tag(map_q, read_reg_addr1_pipe1_i);
   assign read_vld0_pipe0_o      = rd_vld(vld_q, read_reg_addr0_pipe0_i);
   assign read_vld1_pipe0_o      = rd_vld(vld_q, read_reg_addr1_pipe0_i);
   assign read_vld0_pipe1_o      = rd_vld(vld_q, read_reg_addr0_pipe1_i);
   assign read_vld1_pipe1_o      = rd_vld(vld_q, read_reg_addr1_pipe1_i);

   assign ckpt_save_id_o = tail_q;
   assign ckpt_full_o    = (count_q == FULL_CNT);
   assign ckpt_err_o     = err_q;

   // A slot is live when its distance from head is below the occupancy.
   assign rst_dist     = ckpt_restore_id_i - head_q;
   assign restore_live = ({1'b0, rst_dist} < count_q);
   assign rel_ok       = ckpt_release_i && (count_q != '0);
   assign save_ok      = ckpt_save_i && ((count_q != FULL_CNT) || rel_ok);

   // Next-state for table and checkpoints: flush, then restore, then normal rename/commit.
   always_comb begin
      map_d   = map_q;
      vld_d   = apply_pops(map_q, vld_q);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = 1'b0;
      for (int s = 0; s < NUM_CKPT; s++) begin
         ckpt_map_d[s] = ckpt_map_q[s];
         ckpt_vld_d[s] = apply_pops(ckpt_map_q[s], ckpt_vld_q[s]);
      end
      if (flush_i) begin
         vld_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (ckpt_restore_i) begin
         if (restore_live) begin
            map_d   = ckpt_map_q[ckpt_restore_id_i];
            vld_d   = ckpt_vld_d[ckpt_restore_id_i];
            tail_d  = ckpt_restore_id_i + CKPT_W'(1);
            count_d = {1'b0, rst_dist} + (CKPT_W+1)'(1);
         end else begin
            err_d = 1'b1;
         end
      end else begin
         if (push0_i && (push_reg_addr0_i != '0)) begin
            map_d[push_reg_addr0_i] = push_rob_addr0_i;
            vld_d[push_reg_addr0_i] = 1'b1;
         end
         if (push1_i && (push_reg_addr1_i != '0)) begin
            map_d[push_reg_addr1_i] = push_rob_addr1_i;
            vld_d[push_reg_addr1_i] = 1'b1;
         end
         if (save_ok) begin
            ckpt_map_d[tail_q] = map_d;
            ckpt_vld_d[tail_q] = vld_d;
            tail_d             = tail_q + CKPT_W'(1);
         end
         if (rel_ok) head_d = head_q + CKPT_W'(1);
         count_d = count_q + (CKPT_W+1)'(save_ok) - (CKPT_W+1)'(rel_ok);
         err_d   = (ckpt_save_i && !save_ok) || (ckpt_release_i && !rel_ok);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         map_q   <= '0;
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         for (int s = 0; s < NUM_CKPT; s++) begin
            ckpt_map_q[s] <= '0;
            ckpt_vld_q[s] <= '0;
         end
      end else begin
         map_q   <= map_d;
         vld_q   <= vld_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
         for (int s = 0; s < NUM_CKPT; s++) begin
            ckpt_map_q[s] <= ckpt_map_d[s];
            ckpt_vld_q[s] <= ckpt_vld_d[s];
         end
      end
   end

endmodule

// File: tb/tb_rename_table_ckpt.sv
// tb/tb_rename_table_ckpt.sv - randomized bench with queue-based rename/checkpoint model
module tb_rename_table_ckpt;

   localparam int NC = 4;

   typedef logic [31:0][4:0] map_t;
   typedef struct packed {
      logic [1:0]  id;
      map_t        map;
      logic [31:0] vld;
   } snap_t;

   logic       clk = 1'b0;
   logic       reset, flush, push0, push1, pop0, pop1;
   logic [4:0] preg0, preg1, ptag0, ptag1, oreg0, oreg1, otag0, otag1;
   logic [4:0] rra [4];
   logic [4:0] rtag [4];
   logic       rvld [4];
   logic       save, release_c, restore;
   logic [1:0] rid, save_id;
   logic       full, err;

   // model state
   map_t        tmap;
   logic [31:0] tvld;
   snap_t       q[$];
   int          mtail;
   logic        merr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rename_table_ckpt dut (
      .clk_i(clk), .reset_i(reset), .flush_i(flush),
      .push0_i(push0), .push1_i(push1),
      .push_reg_addr0_i(preg0), .push_reg_addr1_i(preg1),
      .push_rob_addr0_i(ptag0), .push_rob_addr1_i(ptag1),
      .read_reg_addr0_pipe0_i(rra[0]), .read_reg_addr1_pipe0_i(rra[1]),
      .read_reg_addr0_pipe1_i(rra[2]), .read_reg_addr1_pipe1_i(rra[3]),
      .read_rob_addr0_pipe0_o(rtag[0]), .read_rob_addr1_pipe0_o(rtag[1]),
      .read_rob_addr0_pipe1_o(rtag[2]), .read_rob_addr1_pipe1_o(rtag[3]),
      .read_vld0_pipe0_o(rvld[0]), .read_vld1_pipe0_o(rvld[1]),
      .read_vld0_pipe1_o(rvld[2]), .read_vld1_pipe1_o(rvld[3]),
      .pop0_i(pop0), .pop1_i(pop1),
      .pop_reg_addr0_i(oreg0), .pop_reg_addr1_i(oreg1),
      .pop_rob_addr0_i(otag0), .pop_rob_addr1_i(otag1),
      .ckpt_save_i(save), .ckpt_save_id_o(save_id),
      .ckpt_release_i(release_c),
      .ckpt_restore_i(restore), .ckpt_restore_id_i(rid),
      .ckpt_full_o(full), .ckpt_err_o(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] popped(input map_t m, input logic [31:0] v);
      logic [31:0] r;
      r = v;
      if (pop0 && oreg0 != 0 && r[oreg0] && m[oreg0] == otag0) r[oreg0] = 1'b0;
      if (pop1 && oreg1 != 0 && r[oreg1] && m[oreg1] == otag1) r[oreg1] = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      tmap  = '0;
      tvld  = '0;
      q.delete();
      mtail = 0;
      merr  = 1'b0;
   endtask

   // One clock edge of the architectural behaviour, using the inputs the DUT just sampled.
   task automatic model_step();
      map_t        nmap;
      logic [31:0] nvld;
      int          idx;
      bit          rel_ok, save_ok;
      snap_t       s;
      if (!reset) begin
         model_reset();
         return;
      end
      foreach (q[i]) q[i].vld = popped(q[i].map, q[i].vld);
      nmap = tmap;
      nvld = popped(tmap, tvld);
      merr = 1'b0;
      if (flush) begin
         nvld  = '0;
         q.delete();
         mtail = 0;
      end else if (restore) begin
         idx = -1;
         foreach (q[i]) if (q[i].id == rid) idx = i;
         if (idx >= 0) begin
            nmap = q[idx].map;
            nvld = q[idx].vld;
            while (q.size() > idx + 1) void'(q.pop_back());
            mtail = (int'(rid) + 1) % NC;
         end else begin
            merr = 1'b1;
         end
      end else begin
         if (push0 && preg0 != 0) begin nmap[preg0] = ptag0; nvld[preg0] = 1'b1; end
         if (push1 && preg1 != 0) begin nmap[preg1] = ptag1; nvld[preg1] = 1'b1; end
         rel_ok = release_c && q.size() > 0;
         if (rel_ok) void'(q.pop_front());
         save_ok = save && q.size() < NC;
         if ((save && !save_ok) || (release_c && !rel_ok)) merr = 1'b1;
         if (save_ok) begin
            s.id  = 2'(mtail);
            s.map = nmap;
            s.vld = nvld;
            q.push_back(s);
            mtail = (mtail + 1) % NC;
         end
      end
      tmap = nmap;
      tvld = nvld;
   endtask

   // Every cycle: all DUT outputs against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rd%0d_tag", k), 32'(rtag[k]), (rra[k] == 0) ? 32'd0 : 32'(tmap[rra[k]]));
         chk($sformatf("rd%0d_vld", k), 32'(rvld[k]), (rra[k] == 0) ? 32'd0 : 32'(tvld[rra[k]]));
      end
      chk("ckpt_full", 32'(full), 32'(q.size() == NC));
      chk("ckpt_save_id", 32'(save_id), 32'(mtail));
      chk("ckpt_err", 32'(err), 32'(merr));
   end

   task automatic idle();
      flush = 0; push0 = 0; push1 = 0; pop0 = 0; pop1 = 0;
      preg0 = 0; preg1 = 0; ptag0 = 0; ptag1 = 0;
      oreg0 = 0; oreg1 = 0; otag0 = 0; otag1 = 0;
      save = 0; release_c = 0; restore = 0; rid = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      idle();
   endtask

   task automatic rand_inputs();
      int r;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) rra[k] = 5'($urandom_range(0, 7));
      push0 = ($urandom_range(0, 1) == 1);
      push1 = ($urandom_range(0, 2) == 0);
      preg0 = 5'($urandom_range(0, 7));
      preg1 = 5'($urandom_range(0, 7));
      ptag0 = 5'($urandom_range(0, 31));
      ptag1 = 5'($urandom_range(0, 31));
      pop0  = ($urandom_range(0, 1) == 1);
      pop1  = ($urandom_range(0, 2) == 0);
      oreg0 = 5'($urandom_range(0, 7));
      oreg1 = 5'($urandom_range(0, 7));
      r = $urandom_range(0, 3);
      if (r == 0 && q.size() > 0) otag0 = q[$urandom_range(0, q.size() - 1)].map[oreg0];
      else if (r != 3)            otag0 = tmap[oreg0];
      else                        otag0 = 5'($urandom_range(0, 31));
      otag1 = ($urandom_range(0, 1) == 1) ? tmap[oreg1] : 5'($urandom_range(0, 31));
      save      = ($urandom_range(0, 4) == 0);
      release_c = ($urandom_range(0, 5) == 0);
      restore   = ($urandom_range(0, 11) == 0);
      rid       = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) begin
         reset = 1'b0;
         model_reset();
      end
   endtask

   initial begin
      reset = 1'b0;
      idle();
      for (int k = 0; k < 4; k++) rra[k] = 0;
      model_reset();
      #2;
      chk("reset_full", 32'(full), 0);
      chk("reset_save_id", 32'(save_id), 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // push, read, matching and non-matching pop
      push0 = 1; preg0 = 5; ptag0 = 3; tick();
      rra[0] = 5; #1;
      chk("r5_tag", 32'(rtag[0]), 3);
      chk("r5_vld", 32'(rvld[0]), 1);
      pop0 = 1; oreg0 = 5; otag0 = 3; tick(); #1;
      chk("r5_pop_vld", 32'(rvld[0]), 0);
      push0 = 1; preg0 = 5; ptag0 = 7; tick();
      pop0 = 1; oreg0 = 5; otag0 = 4; tick(); #1;
      chk("r5_stale_pop_vld", 32'(rvld[0]), 1);
      chk("r5_stale_pop_tag", 32'(rtag[0]), 7);

      // dual push same register, push to r0
      push0 = 1; preg0 = 2; ptag0 = 1; push1 = 1; preg1 = 2; ptag1 = 2; tick();
      rra[1] = 2; #1;
      chk("r2_push1_wins", 32'(rtag[1]), 2);
      push0 = 1; preg0 = 0; ptag0 = 9; tick();
      rra[2] = 0; #1;
      chk("r0_vld", 32'(rvld[2]), 0);
      chk("r0_tag", 32'(rtag[2]), 0);

      // save / overwrite / restore
      push0 = 1; preg0 = 1; ptag0 = 1; tick();
      save = 1; #1;
      chk("save_id_first", 32'(save_id), 0);
      tick();
      push0 = 1; preg0 = 1; ptag0 = 6; tick();
      rra[3] = 1; #1;
      chk("r1_before_restore", 32'(rtag[3]), 6);
      restore = 1; rid = 0; tick(); #1;
      chk("r1_restored_tag", 32'(rtag[3]), 1);
      chk("r1_restored_vld", 32'(rvld[3]), 1);
      chk("restore_tail", 32'(save_id), 1);

      // commit propagates into checkpoint
      flush = 1; tick();
      push0 = 1; preg0 = 1; ptag0 = 1; tick();
      save = 1; tick();
      pop0 = 1; oreg0 = 1; otag0 = 1; tick(); #1;
      chk("r1_popped", 32'(rvld[3]), 0);
      restore = 1; rid = 0; tick(); #1;
      chk("r1_restore_after_pop", 32'(rvld[3]), 0);

      // full, overflow, save+release while full
      flush = 1; tick();
      repeat (4) begin save = 1; tick(); end
      #1;
      chk("full_after4", 32'(full), 1);
      chk("tail_after4", 32'(save_id), 0);
      save = 1; tick(); #1;
      chk("overflow_err", 32'(err), 1);
      tick(); #1;
      chk("err_one_cycle", 32'(err), 0);
      save = 1; release_c = 1; tick(); #1;
      chk("save_rel_full", 32'(full), 1);
      chk("save_rel_tail", 32'(save_id), 1);

      // flush beats restore
      flush = 1; tick();
      push0 = 1; preg0 = 1; ptag0 = 1; push1 = 1; preg1 = 2; ptag1 = 2; save = 1; tick();
      save = 1; tick();
      flush = 1; restore = 1; rid = 0; tick();
      rra[0] = 1; rra[1] = 2; #1;
      chk("flush_r1_vld", 32'(rvld[0]), 0);
      chk("flush_r2_vld", 32'(rvld[1]), 0);
      chk("flush_full", 32'(full), 0);
      chk("flush_tail", 32'(save_id), 0);

      // asynchronous reset in the middle of a save
      push0 = 1; preg0 = 3; ptag0 = 4; tick();
      rra[0] = 3; save = 1; #1;
      reset = 1'b0;
      model_reset();
      #1;
      chk("areset_tag", 32'(rtag[0]), 0);
      chk("areset_vld", 32'(rvld[0]), 0);
      chk("areset_save_id", 32'(save_id), 0);
      chk("areset_err", 32'(err), 0);
      tick();
      reset = 1'b1;
      tick();

      repeat (4000) begin
         rand_inputs();
         tick();
      end
      reset = 1'b1;
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
